// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing unit: FSM encoding,
// the hard-wired zero register and the default divider latency.
package pipe_ctrl_pkg;
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DIV_LAT_DEFAULT = 32;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> sequencing-unit bundle: ID/EXE operand info in, stage controls out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Drs_addr;
  logic [4:0]       Drt_addr;
  logic             Drs_used;
  logic             Drt_used;
  logic [4:0]       Erf_waddr;
  logic             Edmem_rena;
  logic             Ediv_op;
  logic             exc_flush;
  logic             pc_stall;
  logic             fd_stall;
  logic             fd_flush;
  logic             de_stall;
  logic             de_flush;
  logic             em_flush;
  logic             div_start;
  logic             div_abort;
  logic             div_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Drs_addr, Drt_addr, Drs_used, Drt_used, Erf_waddr, Edmem_rena, Ediv_op, exc_flush,
    input  pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_flush,
    input  div_start, div_abort, div_busy, stall_cnt
  );

  modport slave (
    input  Drs_addr, Drt_addr, Drs_used, Drt_used, Erf_waddr, Edmem_rena, Ediv_op, exc_flush,
    output pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_flush,
    output div_start, div_abort, div_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: flags an ID operand that depends on a load sitting in EXE.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_drs_addr,
  input  logic [4:0] i_drt_addr,
  input  logic       i_drs_used,
  input  logic       i_drt_used,
  input  logic [4:0] i_erf_waddr,
  input  logic       i_edmem_rena,
  output logic       o_hz
);
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_drs_used & (i_drs_addr == i_erf_waddr);
  assign w_rt_hit = i_drt_used & (i_drt_addr == i_erf_waddr);
  // $0 is hard-wired, so a load targeting it can never feed a dependent operand
  assign o_hz     = i_edmem_rena & (i_erf_waddr != REG_ZERO) & (w_rs_hit | w_rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing unit: stall/flush controls for load-use hazards, the
// multi-cycle divider and CP0 flushes, plus a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [7:0]       CNT_LOAD = 8'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [7:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_hz;
  logic       w_pc_stall, w_fd_stall, w_fd_flush, w_de_stall, w_de_flush, w_em_flush;
  logic       w_div_start, w_div_abort, w_div_busy;

  hazard_cmp u_hazard_cmp (
    .i_drs_addr   (bus.Drs_addr),
    .i_drt_addr   (bus.Drt_addr),
    .i_drs_used   (bus.Drs_used),
    .i_drt_used   (bus.Drt_used),
    .i_erf_waddr  (bus.Erf_waddr),
    .i_edmem_rena (bus.Edmem_rena),
    .o_hz         (w_hz)
  );

  // Output priority (rst > exc_flush > divider > load-use) and FSM next state
  always_comb begin
    w_pc_stall  = 1'b0;
    w_fd_stall  = 1'b0;
    w_fd_flush  = 1'b0;
    w_de_stall  = 1'b0;
    w_de_flush  = 1'b0;
    w_em_flush  = 1'b0;
    w_div_start = 1'b0;
    w_div_abort = 1'b0;
    w_div_busy  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (rst) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 8'd0;
    end else if (bus.exc_flush) begin
      w_fd_flush  = 1'b1;
      w_de_flush  = 1'b1;
      w_em_flush  = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 8'd0;
      if (r_state != ST_RUN) begin
        w_div_abort = 1'b1;
      end else begin
        w_div_abort = 1'b0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          // The start cycle already holds the divide in EXE
          if (bus.Ediv_op) begin
            w_div_start = 1'b1;
            w_pc_stall  = 1'b1;
            w_fd_stall  = 1'b1;
            w_de_stall  = 1'b1;
            w_em_flush  = 1'b1;
            w_div_busy  = 1'b1;
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = CNT_LOAD;
          end else if (w_hz) begin
            w_pc_stall = 1'b1;
            w_fd_stall = 1'b1;
            w_de_flush = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_BUSY: begin
          w_pc_stall = 1'b1;
          w_fd_stall = 1'b1;
          w_de_stall = 1'b1;
          w_em_flush = 1'b1;
          w_div_busy = 1'b1;
          w_cnt_nxt  = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_DONE: begin
          // Ediv_op here is the finishing divide itself, so no restart
          w_state_nxt = ST_RUN;
          if (w_hz) begin
            w_pc_stall = 1'b1;
            w_fd_stall = 1'b1;
            w_de_flush = 1'b1;
          end else begin
            w_pc_stall = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // FSM, divider countdown and stall performance counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= 8'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pc_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign bus.pc_stall  = w_pc_stall;
  assign bus.fd_stall  = w_fd_stall;
  assign bus.fd_flush  = w_fd_flush;
  assign bus.de_stall  = w_de_stall;
  assign bus.de_flush  = w_de_flush;
  assign bus.em_flush  = w_em_flush;
  assign bus.div_start = w_div_start;
  assign bus.div_abort = w_div_abort;
  assign bus.div_busy  = w_div_busy;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-age reference model.
module tb_pipe_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   fails   = 0;

  // Model: age of the divide in EXE (0 = none, 1..LAT-1 = held, LAT = leaving)
  int          m_age = 0;
  logic [7:0]  m_cnt = 8'd0;
  logic [8:0]  exp_v;
  logic [7:0]  c0;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.DIV_LAT(LAT), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_flush, div_start, div_abort, div_busy}
  wire [8:0] obs = {bus.pc_stall, bus.fd_stall, bus.fd_flush, bus.de_stall, bus.de_flush,
                    bus.em_flush, bus.div_start, bus.div_abort, bus.div_busy};

  function automatic logic [8:0] model_exp();
    logic hz;
    logic [8:0] e;
    hz = bus.Edmem_rena && (bus.Erf_waddr != 5'd0) &&
         ((bus.Drs_used && bus.Drs_addr == bus.Erf_waddr) ||
          (bus.Drt_used && bus.Drt_addr == bus.Erf_waddr));
    e = 9'b000000000;
    if (rst) e = 9'b000000000;
    else if (bus.exc_flush) e = (m_age > 0) ? 9'b001011010 : 9'b001011000;
    else if (m_age == 0 && bus.Ediv_op) e = 9'b110101101;
    else if (m_age >= 1 && m_age < LAT) e = 9'b110101001;
    else if (hz) e = 9'b110010000;
    else e = 9'b000000000;
    return e;
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic [4:0] wa, input logic ld,
                        input logic dv, input logic ex);
    bus.Drs_addr = rs; bus.Drt_addr = rt; bus.Drs_used = rsu; bus.Drt_used = rtu;
    bus.Erf_waddr = wa; bus.Edmem_rena = ld; bus.Ediv_op = dv; bus.exc_flush = ex;
  endtask

  task automatic advance();
    logic [8:0] e;
    e = model_exp();
    @(posedge clk);
    if (rst || bus.exc_flush) m_age = 0;
    else if (m_age == 0 && bus.Ediv_op) m_age = 1;
    else if (m_age == LAT) m_age = 0;
    else if (m_age > 0) m_age = m_age + 1;
    else m_age = 0;
    if (rst) m_cnt = 8'd0;
    else if (e[8]) m_cnt = m_cnt + 8'd1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    #2;
    vectors++;
    if (obs !== 9'd0) begin fails++; $display("FAIL reset_outs actual=%b required=%b", obs, 9'd0); end
    vectors++;
    if (bus.stall_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt actual=%0d required=0", bus.stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    m_age = 0; m_cnt = 8'd0;
    advance();
  endtask

  task automatic test_load_use();
    c0 = m_cnt;
    for (int i = 0; i < 2; i++) begin
      set_in(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, (i == 0), 1'b0, 1'b0);
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL load_use cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      advance();
    end
    vectors++;
    if (bus.stall_cnt - c0 !== 8'd1) begin fails++; $display("FAIL load_use_cnt actual=%0d required=1", bus.stall_cnt - c0); end
  endtask

  task automatic test_zero_unused();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       set_in(5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        1:       set_in(5'd2, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        default: set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL zero_unused pat=%0d actual=%b required=%b", i, obs, exp_v); end
      advance();
    end
  endtask

  task automatic test_divide();
    c0 = m_cnt;
    for (int i = 0; i <= LAT + 1; i++) begin
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, (i <= LAT), 1'b0);
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL divide cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      vectors++;
      if (bus.stall_cnt !== m_cnt) begin fails++; $display("FAIL divide_cnt cyc=%0d actual=%0d required=%0d", i, bus.stall_cnt, m_cnt); end
      advance();
    end
    vectors++;
    if (bus.stall_cnt - c0 !== 8'(LAT)) begin fails++; $display("FAIL divide_total actual=%0d required=%0d", bus.stall_cnt - c0, LAT); end
  endtask

  task automatic test_exc_busy();
    for (int i = 0; i < 6; i++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, (i <= 3), (i == 3));
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL exc_busy cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      advance();
    end
  endtask

  task automatic test_hz_during_div();
    for (int i = 0; i < LAT + 4; i++) begin
      set_in(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, (i != LAT && i < LAT + 2), (i <= LAT), 1'b0);
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL hz_div cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      advance();
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int i = 0; i < 2; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL rst_busy_pre cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      advance();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_age = 0; m_cnt = 8'd0;
    vectors++;
    if (obs !== 9'd0) begin fails++; $display("FAIL rst_busy_outs actual=%b required=%b", obs, 9'd0); end
    vectors++;
    if (bus.stall_cnt !== 8'd0) begin fails++; $display("FAIL rst_busy_cnt actual=%0d required=0", bus.stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    bus.Ediv_op = 1'b0;
    #1;
    exp_v = model_exp();
    vectors++;
    if (obs !== exp_v) begin fails++; $display("FAIL rst_busy_idle actual=%b required=%b", obs, exp_v); end
    for (int i = 0; i <= LAT; i++) begin
      bus.Ediv_op = (i <= LAT);
      #1;
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL rst_busy_restart cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      advance();
      @(negedge clk);
    end
    bus.Ediv_op = 1'b0;
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
      @(negedge clk);
      exp_v = model_exp();
      vectors++;
      if (obs !== exp_v) begin fails++; $display("FAIL random cyc=%0d actual=%b required=%b", i, obs, exp_v); end
      vectors++;
      if (bus.stall_cnt !== m_cnt) begin fails++; $display("FAIL random_cnt cyc=%0d actual=%0d required=%0d", i, bus.stall_cnt, m_cnt); end
      advance();
    end
  endtask

  task automatic test_wrap();
    for (int d = 0; d < 70; d++) begin
      for (int i = 0; i <= LAT; i++) begin
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        exp_v = model_exp();
        vectors++;
        if (obs !== exp_v) begin fails++; $display("FAIL wrap div=%0d cyc=%0d actual=%b required=%b", d, i, obs, exp_v); end
        advance();
      end
    end
    vectors++;
    if (bus.stall_cnt !== m_cnt) begin fails++; $display("FAIL wrap_cnt actual=%0d required=%0d", bus.stall_cnt, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_unused();
    test_divide();
    test_exc_busy();
    test_hz_during_div();
    test_reset_mid_busy();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
